// File: rtl/reg_scoreboard_pkg.sv
// Shared widths, Tnew/Tuse encodings and the hazard predicate for the GPR scoreboard.
// Tnew/Tuse values match the ones the decoder assigns.
package reg_scoreboard_pkg;

   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int TW   = 2;
   localparam int CW   = 2;
   localparam int IW   = CW + 3;

   typedef logic [AW-1:0] reg_addr_t;
   typedef logic [TW-1:0] tnew_t;
   typedef logic [CW-1:0] cnt_t;

   localparam tnew_t TNEW_ALU        = tnew_t'(1);
   localparam tnew_t TNEW_LOAD       = tnew_t'(2);
   localparam tnew_t TNEW_MDU        = tnew_t'(1);
   localparam tnew_t TUSE_BRANCH     = tnew_t'(0);
   localparam tnew_t TUSE_ALU        = tnew_t'(1);
   localparam tnew_t TUSE_STORE_DATA = tnew_t'(2);

   localparam cnt_t CNT_MAX = '1;

   // A pending writer blocks a reader only if its value arrives after the reader needs it.
   function automatic logic pending_hazard(input cnt_t cnt, input tnew_t tnew, input tnew_t tuse);
      return (cnt != '0) && (tnew > tuse);
   endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Pipeline-to-scoreboard signal bundle: issue, writeback, flush, D-stage query and results.
import reg_scoreboard_pkg::*;

interface reg_scoreboard_if;
   logic              flush;
   logic              iss_valid;
   reg_addr_t         iss_rd;
   tnew_t             iss_tnew;
   logic              wb_en;
   reg_addr_t         wb_rd;
   reg_addr_t         q_rs;
   reg_addr_t         q_rt;
   tnew_t             q_tuse_rs;
   tnew_t             q_tuse_rt;
   logic              stall;
   logic              rs_ready;
   logic              rt_ready;
   logic [IW-1:0]     inflight;

   modport master (
      output flush, iss_valid, iss_rd, iss_tnew, wb_en, wb_rd,
             q_rs, q_rt, q_tuse_rs, q_tuse_rt,
      input  stall, rs_ready, rt_ready, inflight
   );

   modport slave (
      input  flush, iss_valid, iss_rd, iss_tnew, wb_en, wb_rd,
             q_rs, q_rt, q_tuse_rs, q_tuse_rt,
      output stall, rs_ready, rt_ready, inflight
   );
endinterface

// File: rtl/reg_scoreboard_sb_entry.sv
// Tracking state for one GPR: number of in-flight writers and the youngest writer's Tnew countdown.
import reg_scoreboard_pkg::*;

module sb_entry (
   input  logic  clk,
   input  logic  reset,
   input  logic  flush,
   input  logic  iss_hit,
   input  tnew_t iss_tnew,
   input  logic  wb_hit,
   output cnt_t  cnt,
   output cnt_t  cnt_next,
   output tnew_t tnew
);

   cnt_t  cnt_reg;
   tnew_t tnew_reg;
   tnew_t tnew_next;

   always_comb begin
      cnt_next  = cnt_reg;
      tnew_next = tnew_reg;
      if (reset || flush) begin
         cnt_next  = '0;
         tnew_next = '0;
      end else begin
         if (iss_hit)
            tnew_next = iss_tnew;
         else if (tnew_reg != '0)
            tnew_next = tnew_reg - tnew_t'(1);

         // Issue and writeback together cancel out; each alone saturates at its bound.
         if (iss_hit && !wb_hit && cnt_reg != CNT_MAX)
            cnt_next = cnt_reg + cnt_t'(1);
         else if (wb_hit && !iss_hit && cnt_reg != '0)
            cnt_next = cnt_reg - cnt_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      cnt_reg  <= cnt_next;
      tnew_reg <= tnew_next;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset && !flush) begin
         if (iss_hit && !wb_hit && cnt_reg == CNT_MAX)
            $error("sb_entry %m: issue with %0d writers already in flight", cnt_reg);
         if (wb_hit && !iss_hit && cnt_reg == '0)
            $error("sb_entry %m: writeback with no writer in flight");
      end
   end
`endif

   assign cnt  = cnt_reg;
   assign tnew = tnew_reg;

endmodule

// File: rtl/reg_scoreboard.sv
// GPR write scoreboard: one sb_entry per register 1..31, combinational D-stage stall query,
// registered count of all in-flight writers.
import reg_scoreboard_pkg::*;

module reg_scoreboard (
   input  logic                 clk,
   input  logic                 reset,
   reg_scoreboard_if.slave      sb
);

   cnt_t          cnt_arr      [NREG];
   cnt_t          cnt_next_arr [NREG];
   tnew_t         tnew_arr     [NREG];
   logic [IW-1:0] inflight_reg;
   logic [IW-1:0] inflight_next;
   logic          wb_clr_rs;
   logic          wb_clr_rt;
   logic          hazard_rs;
   logic          hazard_rt;

   assign cnt_arr[0]      = '0;
   assign cnt_next_arr[0] = '0;
   assign tnew_arr[0]     = '0;

   generate
      for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
         sb_entry u_entry (
            .clk      (clk),
            .reset    (reset),
            .flush    (sb.flush),
            .iss_hit  (sb.iss_valid && sb.iss_rd == reg_addr_t'(gi)),
            .iss_tnew (sb.iss_tnew),
            .wb_hit   (sb.wb_en && sb.wb_rd == reg_addr_t'(gi)),
            .cnt      (cnt_arr[gi]),
            .cnt_next (cnt_next_arr[gi]),
            .tnew     (tnew_arr[gi])
         );
      end
   endgenerate

   // The last writer landing this cycle is visible through the register file bypass.
   assign wb_clr_rs = sb.wb_en && (sb.wb_rd == sb.q_rs) && (cnt_arr[sb.q_rs] == cnt_t'(1));
   assign wb_clr_rt = sb.wb_en && (sb.wb_rd == sb.q_rt) && (cnt_arr[sb.q_rt] == cnt_t'(1));

   assign hazard_rs = (sb.q_rs != '0) && !wb_clr_rs &&
                      pending_hazard(cnt_arr[sb.q_rs], tnew_arr[sb.q_rs], sb.q_tuse_rs);
   assign hazard_rt = (sb.q_rt != '0) && !wb_clr_rt &&
                      pending_hazard(cnt_arr[sb.q_rt], tnew_arr[sb.q_rt], sb.q_tuse_rt);

   assign sb.rs_ready = !hazard_rs;
   assign sb.rt_ready = !hazard_rt;
   assign sb.stall    = hazard_rs | hazard_rt;

   // Summing next-state counts keeps inflight aligned with the counters it reports.
   always_comb begin
      inflight_next = '0;
      for (int i = 1; i < NREG; i++)
         inflight_next = inflight_next + IW'(cnt_next_arr[i]);
   end

   always_ff @(posedge clk) begin
      if (reset)
         inflight_reg <= '0;
      else
         inflight_reg <= inflight_next;
   end

   assign sb.inflight = inflight_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench: stimulus queues expected query results, a negedge monitor compares.
`timescale 1ns/1ps
import reg_scoreboard_pkg::*;

module tb_reg_scoreboard;

   typedef struct packed {
      logic          stall;
      logic          rs_ready;
      logic          rt_ready;
      logic [IW-1:0] inflight;
   } exp_t;

   logic   clk = 1'b0;
   logic   reset;
   logic   chk_valid = 1'b0;
   exp_t   exp_q  [$];
   string  name_q [$];
   int     errors = 0;
   int     checks = 0;

   reg_scoreboard_if sb_if ();

   reg_scoreboard dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sb_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      chk_valid       = 1'b0;
      sb_if.iss_valid = 1'b0;
      sb_if.wb_en     = 1'b0;
      sb_if.flush     = 1'b0;
   endtask

   task automatic expect_out(input string nm, input logic st, input logic rsr,
                             input logic rtr, input int infl);
      exp_t e;
      e.stall    = st;
      e.rs_ready = rsr;
      e.rt_ready = rtr;
      e.inflight = IW'(infl);
      exp_q.push_back(e);
      name_q.push_back(nm);
      chk_valid = 1'b1;
   endtask

   task automatic issue(input int rd, input int tn);
      sb_if.iss_valid = 1'b1;
      sb_if.iss_rd    = reg_addr_t'(rd);
      sb_if.iss_tnew  = tnew_t'(tn);
   endtask

   task automatic wb(input int rd);
      sb_if.wb_en = 1'b1;
      sb_if.wb_rd = reg_addr_t'(rd);
   endtask

   task automatic query(input int rs, input int tu_rs, input int rt, input int tu_rt);
      sb_if.q_rs      = reg_addr_t'(rs);
      sb_if.q_tuse_rs = tnew_t'(tu_rs);
      sb_if.q_rt      = reg_addr_t'(rt);
      sb_if.q_tuse_rt = tnew_t'(tu_rt);
   endtask

   // Monitor: pops one expectation whenever the stimulus marks the cycle as checked.
   always @(negedge clk) begin
      if (chk_valid) begin
         exp_t  e;
         string nm;
         exp_t  act;
         checks++;
         act = '{sb_if.stall, sb_if.rs_ready, sb_if.rt_ready, sb_if.inflight};
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL no_expectation: got stall=%0b rs_ready=%0b rt_ready=%0b inflight=%0d",
                     act.stall, act.rs_ready, act.rt_ready, act.inflight);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (act !== e) begin
               errors++;
               $display("FAIL %s: got stall=%0b rs_ready=%0b rt_ready=%0b inflight=%0d, want stall=%0b rs_ready=%0b rt_ready=%0b inflight=%0d",
                        nm, act.stall, act.rs_ready, act.rt_ready, act.inflight,
                        e.stall, e.rs_ready, e.rt_ready, e.inflight);
            end else begin
               $display("check %s ok: stall=%0b rs_ready=%0b rt_ready=%0b inflight=%0d",
                        nm, act.stall, act.rs_ready, act.rt_ready, act.inflight);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b1;
      sb_if.flush     = 1'b0;
      sb_if.iss_valid = 1'b0;
      sb_if.iss_rd    = '0;
      sb_if.iss_tnew  = '0;
      sb_if.wb_en     = 1'b0;
      sb_if.wb_rd     = '0;
      query(0, 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;

      query(5, 0, 6, 0);
      expect_out("reset_query", 0, 1, 1, 0);
      tick();

      // Load into r8, Tnew=2
      issue(8, TNEW_LOAD);
      tick();
      query(8, TUSE_ALU, 6, 0);
      expect_out("lw_tnew2_tuse1", 1, 0, 1, 1);
      tick();
      expect_out("lw_tnew1_tuse1", 0, 1, 1, 1);
      tick();
      query(8, 0, 6, 0);
      wb(8);
      expect_out("lw_wb_cycle", 0, 1, 1, 1);
      tick();
      expect_out("lw_done", 0, 1, 1, 0);
      tick();

      // Two writers to r9
      issue(9, 1);
      tick();
      issue(9, 2);
      query(9, 0, 6, 0);
      expect_out("r9_second_issue", 1, 0, 1, 1);
      tick();
      wb(9);
      expect_out("r9_first_wb", 1, 0, 1, 2);
      tick();
      expect_out("r9_cnt1_tnew1", 1, 0, 1, 1);
      tick();
      wb(9);
      expect_out("r9_tnew0", 0, 1, 1, 1);
      tick();
      expect_out("r9_done", 0, 1, 1, 0);
      tick();

      // Writeback of the last writer clears the hazard in the same cycle (rt path)
      query(0, 0, 11, 0);
      issue(11, 3);
      tick();
      expect_out("r11_rt_pending", 1, 1, 0, 1);
      tick();
      wb(11);
      expect_out("r11_wb_bypass", 0, 1, 1, 1);
      tick();
      expect_out("r11_done", 0, 1, 1, 0);
      tick();

      // Same-cycle issue and writeback to r10
      query(10, 0, 6, 0);
      issue(10, 1);
      tick();
      issue(10, 2);
      wb(10);
      expect_out("r10_iss_wb_same", 0, 1, 1, 1);
      tick();
      query(10, 1, 6, 0);
      expect_out("r10_tnew_reloaded", 1, 0, 1, 1);
      tick();
      wb(10);
      expect_out("r10_tnew1", 0, 1, 1, 1);
      tick();
      expect_out("r10_done", 0, 1, 1, 0);
      tick();

      // Register 0 is never tracked
      query(0, 0, 6, 0);
      issue(0, 3);
      expect_out("r0_issue", 0, 1, 1, 0);
      tick();
      expect_out("r0_after", 0, 1, 1, 0);
      tick();

      // Flush with r4, r7, r12 in flight; flush wins over a same-cycle issue to r13
      issue(4, 3);
      tick();
      issue(7, 3);
      tick();
      issue(12, 3);
      tick();
      query(4, 0, 7, 0);
      sb_if.flush = 1'b1;
      issue(13, 3);
      expect_out("flush_pre", 1, 0, 0, 3);
      tick();
      expect_out("flush_post", 0, 1, 1, 0);
      tick();
      query(12, 0, 13, 0);
      expect_out("flush_beats_issue", 0, 1, 1, 0);
      tick();

      // Reset wins over a same-cycle issue
      reset = 1'b1;
      issue(5, 3);
      tick();
      reset = 1'b0;
      query(5, 0, 6, 0);
      expect_out("reset_beats_issue", 0, 1, 1, 0);
      tick();
      @(negedge clk);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL unconsumed_expectations: got %0d left, want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
